// File: rtl/conv_pkg.sv
// Shared definitions for the rate-1/2, K=4 convolutional code.
// Used by the encoder and by the Viterbi decoder branch-metric units, so both
// ends of the link agree on one polynomial definition.
//   K      : constraint length (state width K-1)
//   G0, G1 : generator polynomials; bit K-1 taps the current input bit
//   conv_sym(w) : 2-bit symbol {g0, g1} for w = {d, sr}
package conv_pkg;

    localparam int K      = 4;
    localparam int SR_W   = K - 1;
    localparam int TAIL_W = $clog2(K);

    localparam logic [K-1:0] G0 = 4'b1101;
    localparam logic [K-1:0] G1 = 4'b1111;

    typedef enum logic [1:0] {IDLE, DATA, TAIL} enc_state_t;

    function automatic logic [1:0] conv_sym(input logic [K-1:0] w);
        return {^(G0 & w), ^(G1 & w)};
    endfunction

endpackage

// File: rtl/conv_enc_core.sv
// Combinational encoder core: symbol and next shift-register state for one
// input bit.
//   d       : input bit being encoded
//   sr      : current state, sr[SR_W-1] is the most recent past input
//   sym     : encoded symbol {g0, g1}
//   sr_next : state after shifting d in
module conv_enc_core
    import conv_pkg::*;
(
    input  logic            d,
    input  logic [SR_W-1:0] sr,
    output logic [1:0]      sym,
    output logic [SR_W-1:0] sr_next
);

    always_comb begin
        sym     = conv_sym({d, sr});
        sr_next = {d, sr[SR_W-1:1]};
    end

endmodule

// File: rtl/conv_encoder.sv
// Framed rate-1/2, K=4 convolutional encoder with zero-tail termination.
// Each accepted input bit yields one registered 2-bit symbol; after the bit
// marked s_last, K-1 tail symbols (encoded zeros) return the state to 0.
//   clk, rst           : clock, asynchronous active-low reset
//   enable             : low aborts the frame (synchronous) and clears state
//   s_valid/s_ready    : input bit handshake, s_data bit, s_last frame end
//   m_valid/m_ready    : output symbol handshake, m_sym {g0,g1}, m_last on
//                        the final tail symbol
//   sym_count          : symbols emitted in the current frame (saturating)
module conv_encoder
    import conv_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             s_data,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [1:0]       m_sym,
    output logic             m_last,
    output logic [CNT_W-1:0] sym_count
);

    enc_state_t        state, state_nxt;
    logic [SR_W-1:0]   sr, sr_nxt, sr_enc;
    logic [TAIL_W-1:0] tail_cnt, tail_nxt;
    logic              m_valid_nxt, m_last_nxt;
    logic [1:0]        m_sym_nxt, sym_enc;
    logic [CNT_W-1:0]  count_nxt, count_inc;
    logic              advance, accept, enc_d;

    assign advance   = !m_valid || m_ready;
    // Gated by rst so the port reads 0 while reset is held.
    assign s_ready   = rst && enable && (state != TAIL) && advance;
    assign accept    = s_valid && s_ready;
    assign enc_d     = (state == TAIL) ? 1'b0 : s_data;
    assign count_inc = (sym_count == '1) ? sym_count : sym_count + CNT_W'(1);

    conv_enc_core u_core (
        .d       (enc_d),
        .sr      (sr),
        .sym     (sym_enc),
        .sr_next (sr_enc)
    );

    always_comb begin
        state_nxt   = state;
        sr_nxt      = sr;
        tail_nxt    = tail_cnt;
        m_valid_nxt = m_valid;
        m_sym_nxt   = m_sym;
        m_last_nxt  = m_last;
        count_nxt   = sym_count;

        if (!enable) begin
            // Abort: pending symbol is dropped, count is left for inspection.
            state_nxt   = IDLE;
            sr_nxt      = '0;
            tail_nxt    = '0;
            m_valid_nxt = 1'b0;
            m_last_nxt  = 1'b0;
        end else if (advance) begin
            case (state)
                IDLE, DATA: begin
                    if (accept) begin
                        m_valid_nxt = 1'b1;
                        m_sym_nxt   = sym_enc;
                        m_last_nxt  = 1'b0;
                        sr_nxt      = sr_enc;
                        count_nxt   = (state == IDLE) ? CNT_W'(1) : count_inc;
                        if (s_last) begin
                            state_nxt = TAIL;
                            tail_nxt  = TAIL_W'(K - 1);
                        end else begin
                            state_nxt = DATA;
                        end
                    end else begin
                        m_valid_nxt = 1'b0;
                        m_last_nxt  = 1'b0;
                    end
                end
                TAIL: begin
                    m_valid_nxt = 1'b1;
                    m_sym_nxt   = sym_enc;
                    sr_nxt      = sr_enc;
                    tail_nxt    = tail_cnt - TAIL_W'(1);
                    count_nxt   = count_inc;
                    // Counter reaching zero marks the final tail symbol.
                    m_last_nxt  = (tail_cnt == TAIL_W'(1));
                    if (tail_cnt == TAIL_W'(1)) begin
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            sr        <= '0;
            tail_cnt  <= '0;
            m_valid   <= 1'b0;
            m_sym     <= '0;
            m_last    <= 1'b0;
            sym_count <= '0;
        end else begin
            state     <= state_nxt;
            sr        <= sr_nxt;
            tail_cnt  <= tail_nxt;
            m_valid   <= m_valid_nxt;
            m_sym     <= m_sym_nxt;
            m_last    <= m_last_nxt;
            sym_count <= count_nxt;
        end
    end

endmodule

// File: tb/tb_conv_encoder.sv
// Directed self-checking bench for conv_encoder.
module tb_conv_encoder;

    logic        clk = 1'b0;
    logic        rst, enable, s_valid, s_ready, s_data, s_last;
    logic        m_valid, m_ready, m_last;
    logic [1:0]  m_sym;
    logic [15:0] sym_count;

    int checks = 0;
    int failures = 0;

    logic [1:0] got_sym[8];
    logic       got_last[8];
    int         got_n;
    int         stall_err;
    logic       tmo;

    // Frame 1,0,1,1 and hand-derived symbols (4 data + 3 tail).
    logic       fb[4]       = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [1:0] exp_1011[7] = '{2'b11, 2'b11, 2'b10, 2'b11, 2'b10, 2'b10, 2'b11};
    // Single bit 1 frame: 1 data + 3 tail symbols.
    logic [1:0] exp_one[4]  = '{2'b11, 2'b11, 2'b01, 2'b11};

    always #5 clk = ~clk;

    conv_encoder #(.CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_sym     (m_sym),
        .m_last    (m_last),
        .sym_count (sym_count)
    );

    // Runs frame 1,0,1,1 with m_ready low for stall_len cycles starting at
    // cycle stall_at, recording every consumed symbol.
    task automatic stream(input int stall_at, input int stall_len);
        int         idx;
        logic [1:0] held_sym;
        logic       held_last;
        logic [15:0] held_cnt;
        logic       holding;
        idx = 0; got_n = 0; stall_err = 0; holding = 1'b0;
        held_sym = '0; held_last = 1'b0; held_cnt = '0;
        for (int cyc = 0; cyc < 40 && got_n < 7; cyc++) begin
            if (holding && (m_valid !== 1'b1 || m_sym !== held_sym ||
                            m_last !== held_last || sym_count !== held_cnt))
                stall_err++;
            m_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
            s_valid = (idx < 4);
            s_data  = (idx < 4) ? fb[idx] : 1'b0;
            s_last  = (idx == 3);
            #1;
            if (m_valid && !m_ready && s_ready !== 1'b0) stall_err++;
            if (s_valid && s_ready) idx++;
            if (m_valid && m_ready) begin
                got_sym[got_n]  = m_sym;
                got_last[got_n] = m_last;
                got_n++;
            end
            holding   = m_valid && !m_ready;
            held_sym  = m_sym;
            held_last = m_last;
            held_cnt  = sym_count;
            @(negedge clk);
        end
        tmo = (got_n < 7);
        s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b0; enable = 1'b1; s_valid = 1'b1; s_data = 1'b1;
        s_last = 1'b0; m_ready = 1'b1;
        #2;
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
        checks++; if (m_sym !== 2'b00) begin failures++; $display("FAIL reset_m_sym got=%b exp=00", m_sym); end
        checks++; if (m_last !== 1'b0) begin failures++; $display("FAIL reset_m_last got=%b exp=0", m_last); end
        checks++; if (sym_count !== 16'd0) begin failures++; $display("FAIL reset_sym_count got=%0d exp=0", sym_count); end
        checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL reset_s_ready got=%b exp=0", s_ready); end
        @(negedge clk); @(negedge clk);
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_held_m_valid got=%b exp=0", m_valid); end
        s_valid = 1'b0; rst = 1'b1;
        #1;
        checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL idle_s_ready got=%b exp=1", s_ready); end
        @(negedge clk);
    endtask

    task automatic test_single_bit;
        s_valid = 1'b1; s_data = 1'b1; s_last = 1'b1;
        #1;
        checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL single_s_ready got=%b exp=1", s_ready); end
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic el;
            el = (i == 3);
            checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL single_m_valid[%0d] got=%b exp=1", i, m_valid); end
            checks++; if (m_sym !== exp_one[i]) begin failures++; $display("FAIL single_m_sym[%0d] got=%b exp=%b", i, m_sym, exp_one[i]); end
            checks++; if (m_last !== el) begin failures++; $display("FAIL single_m_last[%0d] got=%b exp=%b", i, m_last, el); end
            checks++; if (sym_count !== 16'(i + 1)) begin failures++; $display("FAIL single_count[%0d] got=%0d exp=%0d", i, sym_count, i + 1); end
            if (i < 3) begin
                checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL single_tail_s_ready[%0d] got=%b exp=0", i, s_ready); end
            end
            @(negedge clk);
        end
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL single_end_m_valid got=%b exp=0", m_valid); end
        checks++; if (sym_count !== 16'd4) begin failures++; $display("FAIL single_end_count got=%0d exp=4", sym_count); end
    endtask

    task automatic test_frame;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) begin
                logic el;
                el = (k == 7);
                checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL frame_m_valid[%0d] got=%b exp=1", k - 1, m_valid); end
                checks++; if (m_sym !== exp_1011[k-1]) begin failures++; $display("FAIL frame_m_sym[%0d] got=%b exp=%b", k - 1, m_sym, exp_1011[k-1]); end
                checks++; if (m_last !== el) begin failures++; $display("FAIL frame_m_last[%0d] got=%b exp=%b", k - 1, m_last, el); end
                checks++; if (sym_count !== 16'(k)) begin failures++; $display("FAIL frame_count[%0d] got=%0d exp=%0d", k - 1, sym_count, k); end
            end
            if (k < 4) begin
                s_valid = 1'b1; s_data = fb[k]; s_last = (k == 3);
            end else begin
                s_valid = 1'b0; s_last = 1'b0;
            end
            @(negedge clk);
        end
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL frame_end_m_valid got=%b exp=0", m_valid); end
        checks++; if (sym_count !== 16'd7) begin failures++; $display("FAIL frame_end_count got=%0d exp=7", sym_count); end
    endtask

    task automatic test_backpressure;
        stream(2, 3);
        checks++; if (tmo !== 1'b0) begin failures++; $display("FAIL bp_timeout got=%0d symbols exp=7", got_n); end
        checks++; if (stall_err != 0) begin failures++; $display("FAIL bp_stall_hold got=%0d violations exp=0", stall_err); end
        for (int i = 0; i < 7; i++) begin
            logic el;
            el = (i == 6);
            checks++; if (got_sym[i] !== exp_1011[i]) begin failures++; $display("FAIL bp_sym[%0d] got=%b exp=%b", i, got_sym[i], exp_1011[i]); end
            checks++; if (got_last[i] !== el) begin failures++; $display("FAIL bp_last[%0d] got=%b exp=%b", i, got_last[i], el); end
        end
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL bp_end_m_valid got=%b exp=0", m_valid); end
        checks++; if (sym_count !== 16'd7) begin failures++; $display("FAIL bp_end_count got=%0d exp=7", sym_count); end
    endtask

    task automatic test_tail_stall;
        stream(5, 3);
        checks++; if (tmo !== 1'b0) begin failures++; $display("FAIL tstall_timeout got=%0d symbols exp=7", got_n); end
        checks++; if (stall_err != 0) begin failures++; $display("FAIL tstall_hold got=%0d violations exp=0", stall_err); end
        for (int i = 0; i < 7; i++) begin
            logic el;
            el = (i == 6);
            checks++; if (got_sym[i] !== exp_1011[i]) begin failures++; $display("FAIL tstall_sym[%0d] got=%b exp=%b", i, got_sym[i], exp_1011[i]); end
            checks++; if (got_last[i] !== el) begin failures++; $display("FAIL tstall_last[%0d] got=%b exp=%b", i, got_last[i], el); end
        end
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL tstall_end_m_valid got=%b exp=0", m_valid); end
        checks++; if (sym_count !== 16'd7) begin failures++; $display("FAIL tstall_end_count got=%0d exp=7", sym_count); end
    endtask

    task automatic test_abort;
        s_valid = 1'b1; s_data = 1'b1; s_last = 1'b1;
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0;
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL abort_m_valid got=%b exp=0", m_valid); end
        checks++; if (m_last !== 1'b0) begin failures++; $display("FAIL abort_m_last got=%b exp=0", m_last); end
        checks++; if (sym_count !== 16'd2) begin failures++; $display("FAIL abort_count_hold got=%0d exp=2", sym_count); end
        enable = 1'b1; s_valid = 1'b1; s_data = 1'b1; s_last = 1'b1;
        #1;
        checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL abort_idle_s_ready got=%b exp=1", s_ready); end
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic el;
            el = (i == 3);
            checks++; if (m_sym !== exp_one[i]) begin failures++; $display("FAIL abort_next_sym[%0d] got=%b exp=%b", i, m_sym, exp_one[i]); end
            checks++; if (m_last !== el) begin failures++; $display("FAIL abort_next_last[%0d] got=%b exp=%b", i, m_last, el); end
            @(negedge clk);
        end
    endtask

    task automatic test_async_reset;
        s_valid = 1'b1; s_data = 1'b1; s_last = 1'b0;
        @(negedge clk);
        s_data = 1'b0;
        @(negedge clk);
        s_valid = 1'b0;
        checks++; if (sym_count !== 16'd2) begin failures++; $display("FAIL arst_pre_count got=%0d exp=2", sym_count); end
        #2 rst = 1'b0;
        #1;
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL arst_m_valid got=%b exp=0", m_valid); end
        checks++; if (m_sym !== 2'b00) begin failures++; $display("FAIL arst_m_sym got=%b exp=00", m_sym); end
        checks++; if (m_last !== 1'b0) begin failures++; $display("FAIL arst_m_last got=%b exp=0", m_last); end
        checks++; if (sym_count !== 16'd0) begin failures++; $display("FAIL arst_count got=%0d exp=0", sym_count); end
        checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL arst_s_ready got=%b exp=0", s_ready); end
        @(negedge clk);
        rst = 1'b1;
        s_valid = 1'b1; s_data = 1'b1; s_last = 1'b1;
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic el;
            el = (i == 3);
            checks++; if (m_sym !== exp_one[i]) begin failures++; $display("FAIL arst_next_sym[%0d] got=%b exp=%b", i, m_sym, exp_one[i]); end
            checks++; if (m_last !== el) begin failures++; $display("FAIL arst_next_last[%0d] got=%b exp=%b", i, m_last, el); end
            @(negedge clk);
        end
        checks++; if (sym_count !== 16'd4) begin failures++; $display("FAIL arst_next_count got=%0d exp=4", sym_count); end
    endtask

    task automatic test_back_to_back;
        for (int k = 0; k < 9; k++) begin
            if (k > 0) begin
                logic el;
                int   j;
                j  = (k - 1) % 4;
                el = (j == 3);
                checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL b2b_m_valid[%0d] got=%b exp=1", k - 1, m_valid); end
                checks++; if (m_sym !== exp_one[j]) begin failures++; $display("FAIL b2b_m_sym[%0d] got=%b exp=%b", k - 1, m_sym, exp_one[j]); end
                checks++; if (m_last !== el) begin failures++; $display("FAIL b2b_m_last[%0d] got=%b exp=%b", k - 1, m_last, el); end
                checks++; if (sym_count !== 16'(j + 1)) begin failures++; $display("FAIL b2b_count[%0d] got=%0d exp=%0d", k - 1, sym_count, j + 1); end
            end
            if (k == 0 || k == 4) begin
                s_valid = 1'b1; s_data = 1'b1; s_last = 1'b1;
                #1;
                checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL b2b_s_ready[%0d] got=%b exp=1", k, s_ready); end
            end else begin
                s_valid = 1'b0; s_last = 1'b0;
            end
            @(negedge clk);
        end
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL b2b_end_m_valid got=%b exp=0", m_valid); end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_bit();
        test_frame();
        test_backpressure();
        test_tail_stall();
        test_abort();
        test_async_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv_encoder.md
Name: conv_encoder

Overview:
- Rate-1/2, constraint-length-4 (8-state) convolutional encoder. It is the transmit-side counterpart of the team's Viterbi decoder.
- Accepts a framed serial bit stream through a valid/ready handshake and emits one 2-bit symbol per input bit.
- Zero-terminates every frame with K-1 tail symbols, so the decoder's trace-back starts from state 0.
- Output symbol format matches the decoder's d_in[1:0].

Parameters:
- K, 4, constraint length; state width is K-1 = 3.
- G0, 4'b1101, generator polynomial for sym[1]; bit K-1 taps the current input.
- G1, 4'b1111, generator polynomial for sym[0]; bit K-1 taps the current input.
- CNT_W, 16, width of the frame symbol counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  encoder enable; low aborts the current frame and returns to IDLE with state 0.
- s_valid  in  1  input bit valid.
- s_ready  out  1  encoder can accept an input bit this cycle.
- s_data  in  1  input information bit.
- s_last  in  1  marks the final information bit of a frame.
- m_valid  out  1  output symbol valid.
- m_ready  in  1  downstream accepts the symbol.
- m_sym  out  2  encoded symbol {g0, g1}, driving the decoder's d_in.
- m_last  out  1  marks the final tail symbol of a frame.
- sym_count  out  CNT_W  symbols emitted in the current frame, including tail symbols.

Behaviour:
- Reset (rst=0, async) clears everything: state register sr=3'b000, FSM=IDLE, m_valid=0, m_sym=2'b00, m_last=0, sym_count=0, tail counter=0. s_ready is 0 while rst is asserted.
- Encoding rule:
  - Form w = {d, sr}, where sr[2] is the most recent past input.
  - m_sym[1] = ^(G0 & w); m_sym[0] = ^(G1 & w).
  - Next state sr <= {d, sr[2:1]}.
- Output stage:
  - Single registered stage; a symbol appears on m_sym one cycle after its input bit is accepted.
  - advance = !m_valid || m_ready.
  - The stage holds m_sym, m_last and m_valid stable while m_valid && !m_ready.
- s_ready = enable && (FSM==IDLE || FSM==DATA) && advance. This is combinational from m_ready, so full throughput is one bit per cycle.
- FSM:
  - IDLE: on an accepted input (s_valid && s_ready), clear sym_count to 1, encode, go to DATA. If s_last is also set, go to TAIL instead, with tail counter=K-1.
  - DATA: each accepted bit is encoded and sym_count increments. An accepted bit with s_last=1 loads tail counter=K-1 and moves to TAIL.
  - TAIL: s_ready=0. On each cycle with advance=1:
    - encode d=0, decrement the tail counter, increment sym_count.
    - when the counter reaches 0 (the last tail symbol), set m_last=1 and go to IDLE.
    - after the final tail symbol, sr is 3'b000.
- Cycles with no acceptance while in IDLE or DATA: when advance=1, m_valid drops to 0; sr is unchanged.
- sym_count saturates at all-ones; it holds its value in IDLE until the next frame's first acceptance.
- enable=0 (synchronous, any state, including mid-frame or mid-tail):
  - next edge forces FSM=IDLE, sr=0, tail counter=0, m_valid=0, m_last=0.
  - sym_count holds its value.
  - the symbol pending in the output stage is discarded.
- Simultaneous events:
  - enable=0 overrides any acceptance in the same cycle.
  - s_last on the first bit in IDLE produces a 4-symbol frame: 1 data symbol + 3 tail symbols.
  - back-to-back frames are allowed; a new frame's first bit is accepted the cycle after the FSM returns to IDLE.
- Total symbols per frame = N data bits + K-1.

Decomposition:
- Package conv_pkg holds:
  - localparams K, G0, G1;
  - typedef enum logic [1:0] {IDLE, DATA, TAIL} enc_state_t;
  - function conv_sym(w) returning the 2-bit symbol.
- The decoder's bmc modules use the same package so both ends share one polynomial definition.
- One sub-module, conv_enc_core: the combinational symbol/next-state logic for (d, sr). The FSM, counters and output stage stay in conv_encoder.

Test Plan:
- Single-bit frame: s_data=1, s_last=1 in IDLE with m_ready=1 -> m_sym 2'b11, 2'b11, 2'b01, 2'b11 on consecutive cycles; m_last only on the 4th; sym_count=4; sr=0.
- Frame 1,0,1,1 (last on the final bit), m_ready=1 -> 7 symbols matching a conv_sym reference model; then feed the decoder and check d_out reproduces 1,0,1,1.
- Backpressure: hold m_ready=0 for 3 cycles mid-frame -> s_ready=0, m_sym/m_last stable, no bit lost; output sequence identical to the no-stall case.
- Tail stall: hold m_ready=0 during TAIL -> s_ready stays 0, tail counter does not advance; m_last still appears exactly once.
- Abort: drop enable for one cycle during the second tail symbol -> m_valid=0 next cycle, FSM=IDLE; the next frame encodes from state 0 (first symbol for input 1 is 2'b11).
- Async reset mid-frame: assert rst between clock edges -> m_valid, m_sym, m_last, sym_count clear immediately; after release the first frame behaves as in the first scenario.
